// File: rtl/clip_controller_if.sv
// Sample-memory bus between clip_controller (master) and the clip RAM (slave).
// Build option for the controller: define CLIP_LOOP_EN to make playback loop.
`timescale 1ns/1ps
interface clip_controller_if #(
   parameter int NUM_CLIPS = 4,
   parameter int CLIP_AW   = 10,
   parameter int SAMPLE_W  = 8
);
   localparam int ADDR_W = $clog2(NUM_CLIPS) + CLIP_AW;

   // Strobe protocol, no back-pressure: mem_we writes mem_wdata at mem_addr in
   // the cycle it is high; mem_re requests mem_addr and the slave must present
   // mem_rdata exactly one cycle later. we and re are never high together.
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_we;
   logic                mem_re;
   logic [SAMPLE_W-1:0] mem_wdata;
   logic [SAMPLE_W-1:0] mem_rdata;

   modport master (
      output mem_addr,
      output mem_we,
      output mem_re,
      output mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_we,
      input  mem_re,
      input  mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/clip_controller.sv
// Multi-slot audio clip recorder/player driving an external sample RAM.
// Define CLIP_LOOP_EN to loop playback at end of clip; undefined stops at end.
`timescale 1ns/1ps
module clip_controller #(
   parameter  int NUM_CLIPS = 4,
   parameter  int CLIP_AW   = 10,
   parameter  int SAMPLE_W  = 8,
   localparam int CLIP_BITS = $clog2(NUM_CLIPS)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 PlaySync,
   input  logic                 RecordSync,
   input  logic                 ClipNumPlaySync,
   input  logic                 ClipNumRecordSync,
   input  logic                 resetButtonSync,
   input  logic                 sample_tick,
   input  logic [SAMPLE_W-1:0]  sample_in,
   clip_controller_if.master    mem,
   output logic [SAMPLE_W-1:0]  sample_out,
   output logic                 sample_out_valid,
   output logic [CLIP_BITS-1:0] play_clip,
   output logic [CLIP_BITS-1:0] record_clip,
   output logic [1:0]           state,
   output logic                 busy
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECORD = 2'd1,
      PLAY   = 2'd2
   } ctrlStateT;

   localparam logic [CLIP_AW-1:0]   PTR_LAST = '1;
   localparam logic [CLIP_AW-1:0]   PTR_ONE  = 1;
   localparam logic [CLIP_AW:0]     LEN_ONE  = 1;
   localparam logic [CLIP_AW:0]     FULL_LEN = {1'b1, {CLIP_AW{1'b0}}};
   localparam logic [CLIP_BITS-1:0] CLIP_ONE = 1;

   ctrlStateT         stateQ;
   logic [CLIP_AW-1:0] ptr;
   logic [CLIP_AW:0]   clipLen [NUM_CLIPS];
   logic               readPending;
   logic [CLIP_AW:0]   playLen;
   logic               writeNow;
   logic               readNow;
   logic               lastRead;

   // A stop command or the reset button in the same cycle suppresses the access.
   assign writeNow = (stateQ == RECORD) && sample_tick && !RecordSync && !resetButtonSync;
   assign readNow  = (stateQ == PLAY)   && sample_tick && !PlaySync   && !resetButtonSync;
   assign playLen  = clipLen[play_clip];
   assign lastRead = ({1'b0, ptr} == (playLen - LEN_ONE));

   assign mem.mem_we    = writeNow;
   assign mem.mem_re    = readNow;
   assign mem.mem_addr  = {((stateQ == PLAY) ? play_clip : record_clip), ptr};
   assign mem.mem_wdata = writeNow ? sample_in : '0;

   assign state = stateQ;
   assign busy  = (stateQ != IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stateQ           <= IDLE;
         ptr              <= '0;
         readPending      <= 1'b0;
         play_clip        <= '0;
         record_clip      <= '0;
         sample_out       <= '0;
         sample_out_valid <= 1'b0;
         for (int i = 0; i < NUM_CLIPS; i++) clipLen[i] <= '0;
      end else begin
         // Outstanding reads complete regardless of what the FSM does now.
         readPending      <= readNow;
         sample_out_valid <= readPending;
         if (readPending) sample_out <= mem.mem_rdata;

         if (resetButtonSync) begin
            stateQ      <= IDLE;
            ptr         <= '0;
            play_clip   <= '0;
            record_clip <= '0;
            for (int i = 0; i < NUM_CLIPS; i++) clipLen[i] <= '0;
         end else begin
            case (stateQ)
               IDLE: begin
                  if (RecordSync) begin
                     stateQ <= RECORD;
                     ptr    <= '0;
                  end else if (PlaySync && (playLen != '0)) begin
                     stateQ <= PLAY;
                     ptr    <= '0;
                  end
                  if (ClipNumPlaySync)   play_clip   <= play_clip + CLIP_ONE;
                  if (ClipNumRecordSync) record_clip <= record_clip + CLIP_ONE;
               end
               RECORD: begin
                  if (RecordSync) begin
                     clipLen[record_clip] <= {1'b0, ptr};
                     stateQ               <= IDLE;
                     ptr                  <= '0;
                  end else if (writeNow) begin
                     if (ptr == PTR_LAST) begin
                        clipLen[record_clip] <= FULL_LEN;
                        stateQ               <= IDLE;
                        ptr                  <= '0;
                     end else begin
                        ptr <= ptr + PTR_ONE;
                     end
                  end
               end
               PLAY: begin
                  if (PlaySync) begin
                     stateQ <= IDLE;
                     ptr    <= '0;
                  end else if (readNow) begin
                     if (lastRead) begin
`ifdef CLIP_LOOP_EN
                        ptr <= '0;
`else
                        stateQ <= IDLE;
                        ptr    <= '0;
`endif
                     end else begin
                        ptr <= ptr + PTR_ONE;
                     end
                  end
               end
               default: begin
                  stateQ <= IDLE;
                  ptr    <= '0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_clip_controller.sv
// Directed self-checking bench for clip_controller with a one-cycle-latency RAM model.
`timescale 1ns/1ps
module tb_clip_controller;
   localparam int NUM_CLIPS = 4;
   localparam int CLIP_AW   = 10;
   localparam int SAMPLE_W  = 8;
   localparam int ADDR_W    = 12;

   localparam int P_PLAY    = 0;
   localparam int P_REC     = 1;
   localparam int P_CPLAY   = 2;
   localparam int P_CREC    = 3;
   localparam int P_RBTN    = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic PlaySync = 1'b0, RecordSync = 1'b0, ClipNumPlaySync = 1'b0;
   logic ClipNumRecordSync = 1'b0, resetButtonSync = 1'b0;
   logic sample_tick = 1'b0;
   logic [SAMPLE_W-1:0] sample_in = '0;
   logic [SAMPLE_W-1:0] sample_out;
   logic sample_out_valid;
   logic [1:0] play_clip, record_clip, state;
   logic busy;

   int passCount = 0;
   int checkCount = 0;
   int readCount = 0;
   int bothCount = 0;
   logic [ADDR_W+SAMPLE_W-1:0] wrLog[$];
   logic [SAMPLE_W-1:0] gotLog[$];
   logic [SAMPLE_W-1:0] exp_q[$];
   logic [SAMPLE_W-1:0] memArr [1 << ADDR_W];

   clip_controller_if #(.NUM_CLIPS(NUM_CLIPS), .CLIP_AW(CLIP_AW), .SAMPLE_W(SAMPLE_W)) mem ();

   clip_controller #(.NUM_CLIPS(NUM_CLIPS), .CLIP_AW(CLIP_AW), .SAMPLE_W(SAMPLE_W)) dut (
      .clock(clock),
      .reset(reset),
      .PlaySync(PlaySync),
      .RecordSync(RecordSync),
      .ClipNumPlaySync(ClipNumPlaySync),
      .ClipNumRecordSync(ClipNumRecordSync),
      .resetButtonSync(resetButtonSync),
      .sample_tick(sample_tick),
      .sample_in(sample_in),
      .mem(mem),
      .sample_out(sample_out),
      .sample_out_valid(sample_out_valid),
      .play_clip(play_clip),
      .record_clip(record_clip),
      .state(state),
      .busy(busy)
   );

   // clock / reset-independent infrastructure
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (mem.mem_we) memArr[mem.mem_addr] <= mem.mem_wdata;
      if (mem.mem_re) mem.mem_rdata <= memArr[mem.mem_addr];
   end

   always @(negedge clock) begin
      if (mem.mem_we) wrLog.push_back({mem.mem_addr, mem.mem_wdata});
      if (mem.mem_re) readCount++;
      if (mem.mem_we && mem.mem_re) bothCount++;
      if (sample_out_valid) gotLog.push_back(sample_out);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", passCount, checkCount);
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic pulse(input int which);
      case (which)
         P_PLAY:  PlaySync = 1'b1;
         P_REC:   RecordSync = 1'b1;
         P_CPLAY: ClipNumPlaySync = 1'b1;
         P_CREC:  ClipNumRecordSync = 1'b1;
         default: resetButtonSync = 1'b1;
      endcase
      step(1);
      PlaySync = 1'b0; RecordSync = 1'b0; ClipNumPlaySync = 1'b0;
      ClipNumRecordSync = 1'b0; resetButtonSync = 1'b0;
   endtask

   task automatic tickSample(input logic [SAMPLE_W-1:0] v);
      sample_tick = 1'b1;
      sample_in = v;
      step(1);
      sample_tick = 1'b0;
      sample_in = '0;
      step(1);
   endtask

   task automatic test_reset();
      sample_tick = 1'b1; sample_in = 8'hAA; RecordSync = 1'b1; PlaySync = 1'b1;
      step(3);
      checkCount++; if (state !== 2'd0) $display("FAIL rst_state: got %0d want 0", state); else passCount++;
      checkCount++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else passCount++;
      checkCount++; if (mem.mem_we !== 1'b0) $display("FAIL rst_we: got %0b want 0", mem.mem_we); else passCount++;
      checkCount++; if (mem.mem_re !== 1'b0) $display("FAIL rst_re: got %0b want 0", mem.mem_re); else passCount++;
      checkCount++; if (mem.mem_addr !== 12'd0) $display("FAIL rst_addr: got %0d want 0", mem.mem_addr); else passCount++;
      checkCount++; if (mem.mem_wdata !== 8'd0) $display("FAIL rst_wdata: got %0h want 0", mem.mem_wdata); else passCount++;
      checkCount++; if (sample_out_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", sample_out_valid); else passCount++;
      checkCount++; if (sample_out !== 8'd0) $display("FAIL rst_sample_out: got %0h want 0", sample_out); else passCount++;
      sample_tick = 1'b0; sample_in = '0; RecordSync = 1'b0; PlaySync = 1'b0;
      reset = 1'b0;
      step(1);
   endtask

   task automatic test_record();
      int wb;
      wb = wrLog.size();
      pulse(P_REC);
      checkCount++; if (state !== 2'd1) $display("FAIL rec_enter: got %0d want 1", state); else passCount++;
      checkCount++; if (busy !== 1'b1) $display("FAIL rec_busy: got %0b want 1", busy); else passCount++;
      for (int v = 1; v <= 5; v++) tickSample(8'(v));
      pulse(P_REC);
      checkCount++; if (state !== 2'd0) $display("FAIL rec_stop: got %0d want 0", state); else passCount++;
      checkCount++;
      if (wrLog.size() - wb !== 5) $display("FAIL rec_write_count: got %0d want 5", wrLog.size() - wb);
      else passCount++;
      for (int i = 0; i < 5 && wb + i < wrLog.size(); i++) begin
         checkCount++;
         if (wrLog[wb+i] !== {12'(i), 8'(i + 1)})
            $display("FAIL rec_write_%0d: got %0h want %0h", i, wrLog[wb+i], {12'(i), 8'(i + 1)});
         else passCount++;
      end
   endtask

   task automatic test_play();
      int gb;
      int rb;
      gb = gotLog.size();
      rb = readCount;
      exp_q.delete();
      pulse(P_PLAY);
      checkCount++; if (state !== 2'd2) $display("FAIL play_enter: got %0d want 2", state); else passCount++;
`ifdef CLIP_LOOP_EN
      for (int v = 0; v < 7; v++) begin
         tickSample(8'(v + 1));
         exp_q.push_back(8'((v % 5) + 1));
      end
      checkCount++; if (state !== 2'd2) $display("FAIL play_loop_still: got %0d want 2", state); else passCount++;
      pulse(P_PLAY);
      checkCount++; if (state !== 2'd0) $display("FAIL play_stop: got %0d want 0", state); else passCount++;
`else
      for (int v = 0; v < 4; v++) begin
         tickSample(8'h00);
         exp_q.push_back(8'(v + 1));
      end
      checkCount++; if (state !== 2'd2) $display("FAIL play_mid: got %0d want 2", state); else passCount++;
      sample_tick = 1'b1;
      step(1);
      sample_tick = 1'b0;
      exp_q.push_back(8'd5);
      checkCount++; if (state !== 2'd0) $display("FAIL play_end_idle: got %0d want 0", state); else passCount++;
`endif
      step(3);
      checkCount++;
      if (readCount - rb !== exp_q.size()) $display("FAIL play_reads: got %0d want %0d", readCount - rb, exp_q.size());
      else passCount++;
      checkCount++;
      if (gotLog.size() - gb !== exp_q.size()) $display("FAIL play_valid_count: got %0d want %0d", gotLog.size() - gb, exp_q.size());
      else passCount++;
      for (int i = 0; i < exp_q.size() && gb + i < gotLog.size(); i++) begin
         checkCount++;
         if (gotLog[gb+i] !== exp_q[i]) $display("FAIL play_sample_%0d: got %0h want %0h", i, gotLog[gb+i], exp_q[i]);
         else passCount++;
      end
   endtask

   task automatic test_clip_select();
      int wb;
      int gb;
      repeat (5) pulse(P_CREC);
      checkCount++; if (record_clip !== 2'd1) $display("FAIL clip_rec_wrap: got %0d want 1", record_clip); else passCount++;
      wb = wrLog.size();
      pulse(P_REC);
      pulse(P_CREC);
      checkCount++; if (record_clip !== 2'd1) $display("FAIL clip_rec_locked: got %0d want 1", record_clip); else passCount++;
      tickSample(8'h77);
      pulse(P_REC);
      checkCount++;
      if (wrLog.size() - wb !== 1 || wrLog[wb] !== {12'd1024, 8'h77})
         $display("FAIL clip1_write: got count %0d entry %0h want 1 entry %0h", wrLog.size() - wb,
                  (wrLog.size() > wb) ? wrLog[wb] : 20'h0, {12'd1024, 8'h77});
      else passCount++;
      repeat (3) pulse(P_CREC);
      checkCount++; if (record_clip !== 2'd0) $display("FAIL clip_rec_back0: got %0d want 0", record_clip); else passCount++;
      pulse(P_CPLAY);
      checkCount++; if (play_clip !== 2'd1) $display("FAIL clip_play_inc: got %0d want 1", play_clip); else passCount++;
      gb = gotLog.size();
      pulse(P_PLAY);
      pulse(P_CPLAY);
      checkCount++; if (play_clip !== 2'd1) $display("FAIL clip_play_locked: got %0d want 1", play_clip); else passCount++;
      tickSample(8'h00);
`ifdef CLIP_LOOP_EN
      pulse(P_PLAY);
`endif
      step(2);
      checkCount++; if (state !== 2'd0) $display("FAIL clip1_play_end: got %0d want 0", state); else passCount++;
      checkCount++;
      if (gotLog.size() - gb !== 1 || gotLog[gb] !== 8'h77)
         $display("FAIL clip1_sample: got count %0d want 1 value 77", gotLog.size() - gb);
      else passCount++;
      repeat (3) pulse(P_CPLAY);
      checkCount++; if (play_clip !== 2'd0) $display("FAIL clip_play_wrap: got %0d want 0", play_clip); else passCount++;
   endtask

   task automatic test_empty_and_priority();
      int rb;
      repeat (2) pulse(P_CPLAY);
      rb = readCount;
      pulse(P_PLAY);
      checkCount++; if (state !== 2'd0) $display("FAIL empty_play_state: got %0d want 0", state); else passCount++;
      tickSample(8'h11);
      checkCount++; if (readCount - rb !== 0) $display("FAIL empty_play_reads: got %0d want 0", readCount - rb); else passCount++;
      repeat (3) pulse(P_CREC);
      PlaySync = 1'b1; RecordSync = 1'b1;
      step(1);
      PlaySync = 1'b0; RecordSync = 1'b0;
      checkCount++; if (state !== 2'd1) $display("FAIL rec_wins: got %0d want 1", state); else passCount++;
      pulse(P_PLAY);
      checkCount++; if (state !== 2'd1) $display("FAIL play_ignored_in_rec: got %0d want 1", state); else passCount++;
      pulse(P_REC);
      pulse(P_CPLAY);
      pulse(P_PLAY);
      checkCount++; if (state !== 2'd0) $display("FAIL zero_len_clip_empty: got %0d want 0", state); else passCount++;
      pulse(P_CPLAY);
      pulse(P_CREC);
      pulse(P_PLAY);
      checkCount++; if (state !== 2'd2) $display("FAIL clip0_play_enter: got %0d want 2", state); else passCount++;
      pulse(P_REC);
      checkCount++; if (state !== 2'd2) $display("FAIL rec_ignored_in_play: got %0d want 2", state); else passCount++;
      pulse(P_PLAY);
      checkCount++; if (state !== 2'd0) $display("FAIL play_cmd_stop: got %0d want 0", state); else passCount++;
   endtask

   task automatic test_full_record();
      int wb;
      int gb;
      int rb;
      wb = wrLog.size();
      pulse(P_REC);
      sample_tick = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         sample_in = 8'(i);
         step(1);
      end
      checkCount++; if (state !== 2'd0) $display("FAIL full_auto_idle: got %0d want 0", state); else passCount++;
      #1;
      checkCount++; if (mem.mem_we !== 1'b0) $display("FAIL full_no_wrap_we: got %0b want 0", mem.mem_we); else passCount++;
      step(2);
      sample_tick = 1'b0;
      checkCount++;
      if (wrLog.size() - wb !== 1024) $display("FAIL full_write_count: got %0d want 1024", wrLog.size() - wb);
      else passCount++;
      checkCount++;
      if (wrLog.size() - wb >= 1024 && wrLog[wb+1023] !== {12'd1023, 8'hFF})
         $display("FAIL full_last_write: got %0h want %0h", wrLog[wb+1023], {12'd1023, 8'hFF});
      else passCount++;
      gb = gotLog.size();
      rb = readCount;
      pulse(P_PLAY);
      sample_tick = 1'b1;
      repeat (1024) step(1);
      sample_tick = 1'b0;
`ifdef CLIP_LOOP_EN
      pulse(P_PLAY);
`endif
      checkCount++; if (state !== 2'd0) $display("FAIL full_play_end: got %0d want 0", state); else passCount++;
      step(3);
      checkCount++;
      if (readCount - rb !== 1024) $display("FAIL full_play_reads: got %0d want 1024", readCount - rb);
      else passCount++;
      checkCount++;
      if (gotLog.size() - gb !== 1024 || gotLog[gb+300] !== 8'd44 || gotLog[gb+1023] !== 8'hFF)
         $display("FAIL full_play_data: got count %0d want 1024 with [300]=2c [1023]=ff", gotLog.size() - gb);
      else passCount++;
   endtask

   task automatic test_reset_button();
      int rb;
      int wb;
      repeat (2) pulse(P_CREC);
      pulse(P_PLAY);
      checkCount++; if (state !== 2'd2) $display("FAIL rbtn_play_setup: got %0d want 2", state); else passCount++;
      rb = readCount;
      resetButtonSync = 1'b1; sample_tick = 1'b1;
      #1;
      checkCount++; if (mem.mem_re !== 1'b0) $display("FAIL rbtn_no_read: got %0b want 0", mem.mem_re); else passCount++;
      step(1);
      resetButtonSync = 1'b0; sample_tick = 1'b0;
      checkCount++; if (state !== 2'd0) $display("FAIL rbtn_play_idle: got %0d want 0", state); else passCount++;
      checkCount++; if (record_clip !== 2'd0) $display("FAIL rbtn_rec_clip: got %0d want 0", record_clip); else passCount++;
      checkCount++; if (readCount !== rb) $display("FAIL rbtn_read_count: got %0d want %0d", readCount, rb); else passCount++;
      pulse(P_PLAY);
      checkCount++; if (state !== 2'd0) $display("FAIL rbtn_len0_cleared: got %0d want 0", state); else passCount++;
      pulse(P_CPLAY);
      pulse(P_PLAY);
      checkCount++; if (state !== 2'd0) $display("FAIL rbtn_len1_cleared: got %0d want 0", state); else passCount++;
      pulse(P_CREC);
      pulse(P_REC);
      tickSample(8'h21);
      tickSample(8'h22);
      wb = wrLog.size();
      resetButtonSync = 1'b1; sample_tick = 1'b1; sample_in = 8'h23;
      #1;
      checkCount++; if (mem.mem_we !== 1'b0) $display("FAIL rbtn_no_write: got %0b want 0", mem.mem_we); else passCount++;
      step(1);
      resetButtonSync = 1'b0; sample_tick = 1'b0; sample_in = '0;
      checkCount++; if (state !== 2'd0) $display("FAIL rbtn_rec_idle: got %0d want 0", state); else passCount++;
      checkCount++;
      if (play_clip !== 2'd0 || record_clip !== 2'd0)
         $display("FAIL rbtn_selects: got play %0d rec %0d want 0 0", play_clip, record_clip);
      else passCount++;
      pulse(P_CPLAY);
      pulse(P_PLAY);
      checkCount++; if (state !== 2'd0) $display("FAIL rbtn_abort_no_len: got %0d want 0", state); else passCount++;
      repeat (3) pulse(P_CPLAY);
      checkCount++; if (wrLog.size() !== wb) $display("FAIL rbtn_write_count: got %0d want %0d", wrLog.size(), wb); else passCount++;
   endtask

   task automatic test_async_reset();
      pulse(P_CREC);
      pulse(P_REC);
      tickSample(8'h01);
      tickSample(8'h02);
      sample_tick = 1'b1; sample_in = 8'h5A;
      #1;
      checkCount++;
      if (mem.mem_we !== 1'b1 || mem.mem_addr !== 12'd1026)
         $display("FAIL arst_pre: got we %0b addr %0d want 1 1026", mem.mem_we, mem.mem_addr);
      else passCount++;
      #1 reset = 1'b1;
      #1;
      checkCount++; if (mem.mem_we !== 1'b0) $display("FAIL arst_we: got %0b want 0", mem.mem_we); else passCount++;
      checkCount++; if (mem.mem_addr !== 12'd0) $display("FAIL arst_addr: got %0d want 0", mem.mem_addr); else passCount++;
      checkCount++; if (mem.mem_wdata !== 8'd0) $display("FAIL arst_wdata: got %0h want 0", mem.mem_wdata); else passCount++;
      checkCount++; if (state !== 2'd0 || busy !== 1'b0) $display("FAIL arst_state: got %0d busy %0b want 0 0", state, busy); else passCount++;
      checkCount++; if (record_clip !== 2'd0) $display("FAIL arst_rec_clip: got %0d want 0", record_clip); else passCount++;
      @(posedge clock);
      #1;
      reset = 1'b0; sample_tick = 1'b0; sample_in = '0;
      pulse(P_REC);
      checkCount++; if (state !== 2'd1) $display("FAIL arst_first_edge_cmd: got %0d want 1", state); else passCount++;
      pulse(P_REC);
      checkCount++; if (state !== 2'd0) $display("FAIL arst_rec_stop: got %0d want 0", state); else passCount++;
   endtask

   initial begin
      test_reset();
      test_record();
      test_play();
      test_clip_select();
      test_empty_and_priority();
      test_full_record();
      test_reset_button();
      test_async_reset();
      step(2);
      checkCount++; if (bothCount !== 0) $display("FAIL we_re_exclusive: got %0d overlaps want 0", bothCount); else passCount++;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
